// File: rtl/clk_switch_ctrl.sv
// clk_switch_ctrl: drives the select line of the glitch-free two-clock mux.
// Both mux inputs are watched for activity. A switch request moves sel only
// after the target clock shows enough synchronized edges. The block then
// waits for the mux hand-over to settle and reports done. If the target
// clock never shows enough edges, the request ends with err instead.

// clk_activity_mon: toggle flop in the monitored domain, a 2-flop
// synchronizer into clk_ref, an XOR edge detect and a saturating idle counter.
module clk_activity_mon #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CW          = 7
) (
  input  logic clk_ref,
  input  logic rst,
  input  logic clk_mon,
  output logic edge_pulse,
  output logic alive
);

  localparam logic [CW-1:0] TIMEOUT_V = CW'(TIMEOUT_CYC);

  logic          tog_q,  tog_d;
  logic          meta_q, meta_d;
  logic          sync_q, sync_d;
  logic          prev_q, prev_d;
  logic [CW-1:0] idle_q, idle_d;
  logic          alive_q, alive_d;

  // Toggle flop: the only logic in the monitored clock domain.
  always_comb tog_d = ~tog_q;

  // Toggle register, clocked by the monitored clock itself.
  always_ff @(posedge clk_mon or negedge rst) begin
    if (!rst) tog_q <= 1'b0;
    else      tog_q <= tog_d;
  end

  // Synchronizer chain, idle counter and alive flag next-state.
  always_comb begin
    meta_d = tog_q;
    sync_d = meta_q;
    prev_d = sync_q;
    idle_d = idle_q;
    if (edge_pulse)              idle_d = '0;
    else if (idle_q < TIMEOUT_V) idle_d = idle_q + CW'(1);
    // Compare the next count so that alive_q tracks idle_q exactly.
    alive_d = (idle_d < TIMEOUT_V);
  end

  // Reference-domain registers of the monitor.
  always_ff @(posedge clk_ref or negedge rst) begin
    if (!rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      idle_q  <= '0;
      alive_q <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      idle_q  <= idle_d;
      alive_q <= alive_d;
    end
  end

  assign edge_pulse = sync_q ^ prev_q;
  assign alive      = alive_q;

endmodule

module clk_switch_ctrl #(
  parameter int TIMEOUT_CYC = 64,
  parameter int MIN_EDGES   = 4,
  parameter int SETTLE_CYC  = 8
) (
  input  logic clk_ref,
  input  logic rst,
  input  logic clk0,
  input  logic clk1,
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  output logic sel,
  output logic busy,
  output logic done,
  output logic err,
  output logic clk0_alive,
  output logic clk1_alive
);

  localparam int MAX_AB = (TIMEOUT_CYC > MIN_EDGES) ? TIMEOUT_CYC : MIN_EDGES;
  localparam int MAX_V  = (MAX_AB > SETTLE_CYC) ? MAX_AB : SETTLE_CYC;
  localparam int CW     = $clog2(MAX_V + 1);

  localparam logic [CW-1:0] TIMEOUT_V = CW'(TIMEOUT_CYC);
  localparam logic [CW-1:0] MIN_E_V   = CW'(MIN_EDGES);
  localparam logic [CW-1:0] SETTLE_V  = CW'(SETTLE_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SWITCH,
    S_SETTLE,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic          tgt_q, tgt_d;
  logic          sel_q, sel_d;
  logic [CW-1:0] edge_cnt_q, edge_cnt_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  logic edge0, edge1, edge_tgt;

  clk_activity_mon #(.TIMEOUT_CYC(TIMEOUT_CYC), .CW(CW)) u_mon0 (
    .clk_ref    (clk_ref),
    .rst        (rst),
    .clk_mon    (clk0),
    .edge_pulse (edge0),
    .alive      (clk0_alive)
  );

  clk_activity_mon #(.TIMEOUT_CYC(TIMEOUT_CYC), .CW(CW)) u_mon1 (
    .clk_ref    (clk_ref),
    .rst        (rst),
    .clk_mon    (clk1),
    .edge_pulse (edge1),
    .alive      (clk1_alive)
  );

  assign edge_tgt = tgt_q ? edge1 : edge0;

  // Request FSM next-state: prove target alive, switch, settle, report.
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    sel_d      = sel_q;
    edge_cnt_d = edge_cnt_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          tgt_d = req_sel;
          if (req_sel == sel_q) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_CHECK;
            edge_cnt_d = '0;
            wait_cnt_d = '0;
          end
        end
      end
      S_CHECK: begin
        edge_cnt_d = edge_cnt_q + (edge_tgt ? CW'(1) : CW'(0));
        wait_cnt_d = wait_cnt_q + CW'(1);
        // The edge count is tested first so it wins a tie with the timeout.
        if (edge_cnt_d >= MIN_E_V)        state_d = S_SWITCH;
        else if (wait_cnt_d >= TIMEOUT_V) state_d = S_ERR;
      end
      S_SWITCH: begin
        sel_d      = tgt_q;
        wait_cnt_d = '0;
        state_d    = S_SETTLE;
      end
      S_SETTLE: begin
        wait_cnt_d = wait_cnt_q + CW'(1);
        if (wait_cnt_d >= SETTLE_V) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers; reset forces sel back to clk0 and abandons any request.
  always_ff @(posedge clk_ref or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      tgt_q      <= 1'b0;
      sel_q      <= 1'b0;
      edge_cnt_q <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      sel_q      <= sel_d;
      edge_cnt_q <= edge_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_ERR);
  assign sel       = sel_q;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Testbench for clk_switch_ctrl: directed scenarios followed by randomized
// requests and clock outages, checked cycle by cycle against a request-level
// reference model built from edge counts and cycle offsets.
module tb_clk_switch_ctrl;

  localparam int TIMEOUT = 64;
  localparam int MINE    = 4;
  localparam int SETTLE  = 8;
  localparam int HN      = 32768;

  logic clk_ref = 1'b0;
  logic clk0 = 1'b0;
  logic clk1 = 1'b0;
  logic rst = 1'b0;
  logic req_valid = 1'b0;
  logic req_sel = 1'b0;
  logic en0 = 1'b1;
  logic en1 = 1'b1;
  logic req_ready, sel, busy, done, err, clk0_alive, clk1_alive;

  int checks = 0;
  int failures = 0;

  clk_switch_ctrl #(.TIMEOUT_CYC(TIMEOUT), .MIN_EDGES(MINE), .SETTLE_CYC(SETTLE)) dut (
    .clk_ref    (clk_ref),
    .rst        (rst),
    .clk0       (clk0),
    .clk1       (clk1),
    .req_valid  (req_valid),
    .req_sel    (req_sel),
    .req_ready  (req_ready),
    .sel        (sel),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .clk0_alive (clk0_alive),
    .clk1_alive (clk1_alive)
  );

  // clk_ref: posedges at 5+10n. clk0 = clk_ref/2 and clk1 = clk_ref/3, both
  // phased so their edges never coincide with a clk_ref edge.
  initial forever #5 clk_ref = ~clk_ref;
  initial begin
    #1;
    forever begin
      if (en0) clk0 = ~clk0;
      #10;
    end
  end
  initial begin
    #2;
    forever begin
      if (en1) clk1 = ~clk1;
      #15;
    end
  end

  // Parity of monitored-clock rising edges since reset release.
  logic par0 = 1'b0;
  logic par1 = 1'b0;
  always @(posedge clk0 or negedge rst) begin
    if (!rst) par0 <= 1'b0;
    else      par0 <= ~par0;
  end
  always @(posedge clk1 or negedge rst) begin
    if (!rst) par1 <= 1'b0;
    else      par1 <= ~par1;
  end

  // Cycle index since reset release and per-cycle parity history.
  int   p = 0;
  logic h0 [HN];
  logic h1 [HN];
  always @(posedge clk_ref) begin
    if (!rst) begin
      p <= 0;
    end else begin
      if (p < HN - 1) begin
        h0[p+1] <= par0;
        h1[p+1] <= par1;
      end
      p <= p + 1;
    end
  end

  // Edge parity seen just before clk_ref edge i (0 before the first edge).
  function automatic logic s_of(input int i, input logic w);
    if (i < 1) return 1'b0;
    return w ? h1[i] : h0[i];
  endfunction

  // A synchronized edge is reported in cycle c when the parity changed two
  // clk_ref edges earlier (two-flop synchronizer plus edge detect).
  function automatic logic edge_of(input int c, input logic w);
    return s_of(c - 1, w) ^ s_of(c - 2, w);
  endfunction

  // Reference model state.
  logic m_act, m_noop, m_res, m_ok, m_tgt, m_sel, m_ready;
  int   m_a, m_k, m_edges, last0, last1;
  logic e_busy, e_done, e_err, e_a0, e_a1;

  int a_cyc, eat, dseen, sc, dc;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, p, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, p, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_act   = 1'b0;
    m_sel   = 1'b0;
    m_ready = 1'b1;
    last0   = -1;
    last1   = -1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_sel", sel, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_alive0", clk0_alive, 1'b0);
    chk("rst_alive1", clk1_alive, 1'b0);
  endtask

  // Advance one clk_ref cycle, update the model and compare every output.
  task automatic step();
    logic acc;
    logic t;
    acc = req_valid && m_ready;
    t   = req_sel;
    @(posedge clk_ref);
    @(negedge clk_ref);
    if (edge_of(p - 1, 1'b0)) last0 = p - 1;
    if (edge_of(p - 1, 1'b1)) last1 = p - 1;
    e_a0   = (p >= 1) && (p - last0 - 1 < TIMEOUT);
    e_a1   = (p >= 1) && (p - last1 - 1 < TIMEOUT);
    e_busy = 1'b0;
    e_done = 1'b0;
    e_err  = 1'b0;
    if (acc) begin
      m_act   = 1'b1;
      m_a     = p;
      m_tgt   = t;
      m_noop  = (t == m_sel);
      m_edges = 0;
      m_res   = 1'b0;
      m_ok    = 1'b0;
      m_k     = 0;
    end
    if (m_act) begin
      e_busy = 1'b1;
      if (m_noop) begin
        e_done = 1'b1;
        m_act  = 1'b0;
      end else if (!m_res) begin
        if (edge_of(p, m_tgt)) m_edges++;
        if (m_edges >= MINE) begin
          m_res = 1'b1;
          m_ok  = 1'b1;
          m_k   = p - m_a + 1;
        end else if (p - m_a + 1 >= TIMEOUT) begin
          m_res = 1'b1;
          m_k   = TIMEOUT;
        end
      end else if (m_ok) begin
        if (p == m_a + m_k + 1) m_sel = m_tgt;
        if (p == m_a + m_k + 1 + SETTLE) begin
          e_done = 1'b1;
          m_act  = 1'b0;
        end
      end else if (p == m_a + m_k) begin
        e_err = 1'b1;
        m_act = 1'b0;
      end
    end
    m_ready = !e_busy;
    chk("sel", sel, m_sel);
    chk("ready", req_ready, m_ready);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("err", err, e_err);
    chk("alive0", clk0_alive, e_a0);
    chk("alive1", clk1_alive, e_a1);
  endtask

  task automatic request(input logic r);
    int n;
    n = 0;
    while (!m_ready && n < 200) begin
      step();
      n++;
    end
    if (!m_ready) chk("request_ready_bound", req_ready, 1'b1);
    req_valid = 1'b1;
    req_sel   = r;
    step();
    req_valid = 1'b0;
  endtask

  // Run until the model is idle, poking ignored requests while busy.
  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (!m_ready && n < bound) begin
      req_valid = ($urandom_range(0, 3) == 0);
      req_sel   = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    req_valid = 1'b0;
    if (!m_ready) chk("wait_idle_bound", req_ready, 1'b1);
  endtask

  task automatic do_reset();
    #3;
    rst = 1'b0;
    #1;
    chk_reset_vals();
    @(negedge clk_ref);
    @(negedge clk_ref);
    chk_reset_vals();
    req_valid = 1'b0;
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired at cycle=%0d", p);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk_ref);
    chk_reset_vals();
    rst = 1'b1;

    // Both clocks running: alive within 10 cycles, idle on clk0.
    repeat (10) step();
    chk("alive0_after_10", clk0_alive, 1'b1);
    chk("alive1_after_10", clk1_alive, 1'b1);
    chk("idle_sel", sel, 1'b0);
    chk("idle_ready", req_ready, 1'b1);

    // No-op request, then a request held during busy that must be ignored.
    req_valid = 1'b1;
    req_sel   = 1'b0;
    step();
    chk("noop_done_next_cycle", done, 1'b1);
    req_sel = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    chk("ignored_req_sel", sel, 1'b0);
    chk("ignored_req_busy", busy, 1'b0);

    // Target clock dead: err exactly TIMEOUT cycles after CHECK entry.
    en1 = 1'b0;
    repeat (70) step();
    request(1'b1);
    a_cyc = m_a;
    eat   = -1;
    dseen = 0;
    for (int i = 0; i < 80 && eat < 0; i++) begin
      step();
      if (err === 1'b1) eat = p - a_cyc;
      if (done === 1'b1) dseen++;
    end
    chk_int("err_after_check_entry", eat, TIMEOUT);
    chk_int("done_during_err", dseen, 0);
    chk("sel_after_err", sel, 1'b0);

    // Target clock running: switch to clk1, done SETTLE cycles after sel.
    en1 = 1'b1;
    repeat (10) step();
    request(1'b1);
    sc = -1;
    dc = -1;
    for (int i = 0; i < 100 && dc < 0; i++) begin
      step();
      if (sc < 0 && sel === 1'b1) sc = p;
      if (done === 1'b1) dc = p;
    end
    chk_int("done_after_sel", dc - sc, SETTLE);

    // clk0 outage while idle, then restart.
    en0 = 1'b0;
    repeat (80) step();
    chk("alive0_stopped", clk0_alive, 1'b0);
    en0 = 1'b1;
    repeat (10) step();
    chk("alive0_restarted", clk0_alive, 1'b1);

    // Back to clk0, then reset in the middle of SETTLE after moving to clk1.
    request(1'b0);
    wait_idle(200);
    request(1'b1);
    for (int i = 0; i < 100 && sel !== 1'b1; i++) step();
    step();
    step();
    chk("settle_busy", busy, 1'b1);
    do_reset();
    dseen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done === 1'b1) dseen++;
    end
    chk_int("done_after_reset", dseen, 0);

    // Randomized requests with random clock outages and idle gaps.
    for (int it = 0; it < 40; it++) begin
      en0 = ($urandom_range(0, 4) != 0);
      en1 = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 5) == 0) repeat (70) step();
      else repeat ($urandom_range(0, 5)) step();
      request(1'($urandom_range(0, 1)));
      wait_idle(200);
    end
    en0 = 1'b1;
    en1 = 1'b1;
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_switch_ctrl.md
Name: clk_switch_ctrl

Overview:
- Control block that drives the select input of the team's glitch-free two-clock output mux. It is the requesting end of the clock-switch interface; the mux is the responding end.
- Runs on an always-on reference clock, clk_ref.
- Monitors clk0 and clk1 for activity and accepts switch requests over a valid/ready handshake.
- Moves sel only after the target clock is proven alive. It then waits for the mux's internal hand-over to settle and reports done or err.

Parameters:
- TIMEOUT_CYC, 64: clk_ref cycles without an observed edge before a monitored clock is declared dead. This is also the CHECK-state limit.
- MIN_EDGES, 4: synchronized target-clock edges that must be seen in CHECK before sel moves.
- SETTLE_CYC, 8: clk_ref cycles held in SETTLE after sel changes, before done is reported.

Ports:
- clk_ref  in  1  reference clock; all control logic runs here
- rst  in  1  reset, asynchronous, active-low; resets every flop in all three clock domains
- clk0  in  1  mux input clock 0, monitored only
- clk1  in  1  mux input clock 1, monitored only
- req_valid  in  1  switch request valid
- req_sel  in  1  requested clock: 0 selects clk0, 1 selects clk1
- req_ready  out  1  high when a request can be accepted
- sel  out  1  select line to the glitch-free mux
- busy  out  1  high while a request is in progress
- done  out  1  one-cycle pulse when a request completes successfully
- err  out  1  one-cycle pulse when a request is aborted because the target clock is dead
- clk0_alive  out  1  clk0 has toggled within the last TIMEOUT_CYC clk_ref cycles
- clk1_alive  out  1  clk1 has toggled within the last TIMEOUT_CYC clk_ref cycles

Behaviour:
- Reset values:
  - sel=0, busy=0, done=0, err=0, clk0_alive=0, clk1_alive=0, req_ready=1.
  - FSM in IDLE, all counters 0.
  - Reset is asserted asynchronously and released on its own; no synchronous release is required from this block.
- Activity monitor (identical for each monitored clock n):
  - A toggle flop clocked on posedge clk_n.
  - A 2-flop synchronizer into clk_ref, followed by an XOR edge detect giving edge_n, one cycle per toggle.
  - An idle counter clears on edge_n, increments otherwise, and saturates at TIMEOUT_CYC.
  - clk_n_alive is registered: 1 when the idle counter is below TIMEOUT_CYC.
  - Monitored clock frequency must be at most the clk_ref frequency.
- Handshake:
  - A request is accepted on the clk_ref edge where req_valid and req_ready are both 1.
  - req_sel is latched on acceptance as tgt.
  - req_ready equals (state==IDLE); busy equals (state!=IDLE).
  - req_valid while not ready is ignored, not queued.
- FSM states:
  - IDLE: on accept with tgt==sel, go to DONE (no-op request). On accept with tgt!=sel, go to CHECK and clear edge_cnt and wait_cnt.
  - CHECK: edge_cnt counts edge_tgt and wait_cnt counts every cycle.
    - When edge_cnt reaches MIN_EDGES, go to SWITCH.
    - Otherwise, when wait_cnt reaches TIMEOUT_CYC, go to ERR.
    - If both happen in the same cycle, the edge count wins and the FSM goes to SWITCH.
  - SWITCH: sel<=tgt registered for exactly one cycle, then go to SETTLE with wait_cnt cleared.
  - SETTLE: hold for SETTLE_CYC cycles, then go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
  - ERR: err=1 for one cycle, sel unchanged, then go to IDLE.
- Latency:
  - Accept at edge T. A no-op request gives done high in cycle T+1.
  - A normal switch gives sel changed at T+1+k+1, where k is the number of cycles spent in CHECK. done follows SETTLE_CYC cycles after that.
- Boundaries and invariants:
  - sel changes only on the SWITCH transition.
  - done and err are never high together, and never high outside DONE/ERR.
  - Asserting rst mid-operation aborts immediately: sel returns to 0 and no done/err is emitted.
  - Counter widths are sized to hold TIMEOUT_CYC without wrap.

Test Plan:
- Reset, then clk0=clk_ref/2 and clk1=clk_ref/3 both running: within 10 cycles clk0_alive=clk1_alive=1, sel=0, req_ready=1.
- Request req_sel=1 with clk1 running: sel goes 0->1 after at least 4 clk1 toggles are seen. done pulses 8 cycles after the sel change. busy is high from the cycle after acceptance until done.
- Request req_sel=1 with clk1 stopped: err pulses exactly 64 cycles after CHECK entry, sel stays 0, done never asserts.
- Request req_sel=0 while sel=0: done pulses on the next cycle, with no CHECK. A second req_valid during busy is ignored.
- Stop clk0 while idle: clk0_alive drops 64 clk_ref cycles after the last synchronized edge, and reasserts within 4 cycles of clk0 restarting.
- Assert rst during SETTLE after switching to 1: all outputs return to reset values asynchronously, and no done pulse appears after release.
